micro_sequencer: RTL and testbench
==================================

MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 Parameter: UPC_W, default 8, micro-PC width; the dispatch targets below SHALL assume UPC_W = 8.
REQ-002 clock  input  1  system clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 ubr  input  3  micro-branch type of the current micro-instruction: 0=N, 1=J, 2=EZ, 3=NZ, 4=D, 5=S, 6=F, 7=H.
REQ-005 utarget  input  UPC_W  jump target used by the J, EZ and NZ micro-branch types.
REQ-006 opcode  input  7  opcode field of the instruction register, used by the D micro-branch type.
REQ-007 busy  input  1  memory busy, used by the S micro-branch type.
REQ-008 zero  input  1  ALU zero flag, used by the EZ and NZ micro-branch types.
REQ-009 upc  output  UPC_W  current micro-PC, which addresses the microcode ROM that drives the register file's addr, RegWrt and enReg bus controls.
REQ-010 ustall  output  1  high while the S micro-branch type is active and busy=1.
REQ-011 illegal  output  1  sticky flag set when an unknown opcode is dispatched.
REQ-012 halted  output  1  sticky flag set when the H micro-branch type executes.
REQ-013 ucycles  output  32  count of micro-cycles.
REQ-014 retired  output  32  count of executed F micro-branches.

Function
REQ-015 The next micro-PC for each micro-branch type SHALL be:
- N: upc+1
- J: utarget
- EZ: utarget if zero=1, else upc+1
- NZ: utarget if zero=0, else upc+1
- D: dispatch(opcode)
- S: upc if busy=1, else upc+1
- F: 0x00
- H: upc held
REQ-016 upc+1 SHALL wrap from 0xFF to 0x00, with no flag raised.
REQ-017 dispatch() SHALL map opcodes to micro-PC values as follows:
- 0110011 -> 0x10
- 0010011 -> 0x20
- 0000011 -> 0x30
- 0100011 -> 0x40
- 1100011 -> 0x50
- 1101111 -> 0x60
- 1100111 -> 0x70
- 0110111 -> 0x80
- 0010111 -> 0x90
- any other opcode -> 0xF0
REQ-018 A D micro-branch with an unmapped opcode SHALL set illegal=1 on the same edge that loads upc=0xF0.
REQ-019 ustall SHALL be combinational: ustall = (ubr==S) && busy && !halted.
REQ-020 Each micro-PC transition SHALL take exactly one clock; the new upc SHALL be visible after the edge.
REQ-021 Once halted=1, upc SHALL freeze and all ubr values SHALL be ignored until reset; illegal SHALL retain its value.
REQ-022 When H and any other event occur in the same cycle, H SHALL take priority; halted SHALL rise on that edge and upc SHALL be unchanged.
REQ-023 An S micro-branch with busy=0 SHALL behave exactly as N, with no stall cycle inserted.
REQ-024 busy and zero SHALL be ignored for every micro-branch type that does not reference them.

Reset
REQ-025 While reset=0, the block SHALL asynchronously force upc=0x00, illegal=0, halted=0, ucycles=0 and retired=0.
REQ-026 If reset is asserted mid-operation, including during a spin, the first edge after release SHALL evaluate ubr from upc=0x00.

Configuration
REQ-027 The macro SEQ_PERF_CNT_EN SHALL control the performance counters.
REQ-028 With SEQ_PERF_CNT_EN defined, ucycles SHALL increment on every edge while halted=0, and retired SHALL increment on every F micro-branch while halted=0.
REQ-029 With SEQ_PERF_CNT_EN defined, both counters SHALL wrap at 2^32.
REQ-030 Without SEQ_PERF_CNT_EN, ucycles and retired SHALL be constant 0, no counter registers SHALL be synthesised, and all other behaviour SHALL be identical.

Verification
REQ-031 Reset check: hold reset=0 for 2 cycles, release, then apply ubr=N for 3 cycles -> upc reaches 0x01, 0x02, 0x03 in turn; illegal=0 and halted=0.
REQ-032 Dispatch check: apply ubr=D with opcode=0100011 -> upc=0x40; then ubr=D with opcode=1111111 -> upc=0xF0 and illegal=1; then ubr=F -> upc=0x00 and illegal stays 1.
REQ-033 Spin check: apply ubr=S with busy=1 for 3 cycles, then busy=0 -> upc is unchanged for 3 edges with ustall=1, then advances by 1 with ustall=0.
REQ-034 Branch and wrap check:
- At upc=0x05, apply ubr=EZ, utarget=0x22, zero=1 -> upc=0x22.
- At upc=0x05, apply ubr=EZ, utarget=0x22, zero=0 -> upc=0x06.
- At upc=0xFF, apply ubr=N -> upc=0x00.
REQ-035 Halt and reset check: apply ubr=H, then ubr=J with utarget=0x55 -> upc is frozen and halted=1; assert reset asynchronously mid-cycle -> upc=0x00 and halted=0 immediately, without waiting for a clock edge.
REQ-036 Counter check, with SEQ_PERF_CNT_EN defined: run 10 cycles containing 2 F micro-branches -> ucycles=10 and retired=2; without the macro, both outputs read 0.

Source files
------------

// File: rtl/micro_sequencer.sv
// Microcode sequencer: computes the next micro-PC from the micro-branch type, opcode dispatch,
// memory busy and ALU zero. Optional performance counters are enabled by defining SEQ_PERF_CNT_EN.
module micro_sequencer #(
  parameter int UPC_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [2:0]       ubr,
  input  logic [UPC_W-1:0] utarget,
  input  logic [6:0]       opcode,
  input  logic             busy,
  input  logic             zero,
  output logic [UPC_W-1:0] upc,
  output logic             ustall,
  output logic             illegal,
  output logic             halted,
  output logic [31:0]      ucycles,
  output logic [31:0]      retired
);

  typedef enum logic [2:0] {
    BR_N  = 3'd0,
    BR_J  = 3'd1,
    BR_EZ = 3'd2,
    BR_NZ = 3'd3,
    BR_D  = 3'd4,
    BR_S  = 3'd5,
    BR_F  = 3'd6,
    BR_H  = 3'd7
  } ubr_t;

  ubr_t             br;
  logic [UPC_W-1:0] upc_inc;
  logic [UPC_W-1:0] upc_next;
  logic [UPC_W:0]   disp;
  logic             disp_miss;

  // Returns {unmapped, target}; unmapped opcodes land on the illegal-instruction handler at 0xF0.
  function automatic logic [UPC_W:0] dispatch(input logic [6:0] op);
    logic [UPC_W:0] r;
    r = {1'b0, UPC_W'(8'h00)};
    case (op)
      7'b0110011: r[UPC_W-1:0] = UPC_W'(8'h10);
      7'b0010011: r[UPC_W-1:0] = UPC_W'(8'h20);
      7'b0000011: r[UPC_W-1:0] = UPC_W'(8'h30);
      7'b0100011: r[UPC_W-1:0] = UPC_W'(8'h40);
      7'b1100011: r[UPC_W-1:0] = UPC_W'(8'h50);
      7'b1101111: r[UPC_W-1:0] = UPC_W'(8'h60);
      7'b1100111: r[UPC_W-1:0] = UPC_W'(8'h70);
      7'b0110111: r[UPC_W-1:0] = UPC_W'(8'h80);
      7'b0010111: r[UPC_W-1:0] = UPC_W'(8'h90);
      default:    r = {1'b1, UPC_W'(8'hF0)};
    endcase
    return r;
  endfunction

  assign br        = ubr_t'(ubr);
  assign upc_inc   = upc + UPC_W'(1);
  assign disp      = dispatch(opcode);
  assign disp_miss = disp[UPC_W];
  assign ustall    = (br == BR_S) && busy && !halted;

  always_comb begin
    upc_next = upc_inc;
    case (br)
      BR_N:    upc_next = upc_inc;
      BR_J:    upc_next = utarget;
      BR_EZ:   upc_next = zero ? utarget : upc_inc;
      BR_NZ:   upc_next = zero ? upc_inc : utarget;
      BR_D:    upc_next = disp[UPC_W-1:0];
      BR_S:    upc_next = busy ? upc : upc_inc;
      BR_F:    upc_next = '0;
      BR_H:    upc_next = upc;
      default: upc_next = upc_inc;
    endcase
  end

  // Once halted, every register holds until reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      upc     <= '0;
      illegal <= 1'b0;
      halted  <= 1'b0;
    end else if (!halted) begin
      upc <= upc_next;
      if (br == BR_D && disp_miss) illegal <= 1'b1;
      if (br == BR_H)              halted  <= 1'b1;
    end
  end

`ifdef SEQ_PERF_CNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ucycles <= '0;
      retired <= '0;
    end else if (!halted) begin
      ucycles <= ucycles + 32'd1;
      if (br == BR_F) retired <= retired + 32'd1;
    end
  end
`else
  assign ucycles = '0;
  assign retired = '0;
`endif

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed, table-driven bench for micro_sequencer; counter expectations follow SEQ_PERF_CNT_EN.
module tb_micro_sequencer;

  localparam logic [2:0] N = 3'd0, J = 3'd1, EZ = 3'd2, NZ = 3'd3,
                         D = 3'd4, S = 3'd5, F = 3'd6, H = 3'd7;

  logic        clock;
  logic        reset;
  logic [2:0]  ubr;
  logic [7:0]  utarget;
  logic [6:0]  opcode;
  logic        busy;
  logic        zero;
  logic [7:0]  upc;
  logic        ustall;
  logic        illegal;
  logic        halted;
  logic [31:0] ucycles;
  logic [31:0] retired;

  micro_sequencer #(.UPC_W(8)) dut (
    .clock   (clock),
    .reset   (reset),
    .ubr     (ubr),
    .utarget (utarget),
    .opcode  (opcode),
    .busy    (busy),
    .zero    (zero),
    .upc     (upc),
    .ustall  (ustall),
    .illegal (illegal),
    .halted  (halted),
    .ucycles (ucycles),
    .retired (retired)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [2:0] ubr;
    logic [7:0] utarget;
    logic [6:0] opcode;
    logic       busy;
    logic       zero;
    logic [7:0] exp_upc;
    logic       exp_stall;
    logic       exp_ill;
    logic       exp_halt;
  } vec_t;

  vec_t tbl[64];
  int   ntbl;
  int   checks;
  int   errors;
  logic [31:0] exp_cyc;
  logic [31:0] exp_ret;

  function automatic vec_t mk(input logic [2:0] b, input logic [7:0] t, input logic [6:0] op,
                              input logic bz, input logic z, input logic [7:0] eu,
                              input logic es, input logic ei, input logic eh);
    vec_t v;
    v.ubr = b; v.utarget = t; v.opcode = op; v.busy = bz; v.zero = z;
    v.exp_upc = eu; v.exp_stall = es; v.exp_ill = ei; v.exp_halt = eh;
    return v;
  endfunction

  task automatic add(input vec_t v);
    tbl[ntbl] = v;
    ntbl++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called just after a falling edge: drive, check combinational stall, clock, check state.
  task automatic step(input vec_t v, input string nm);
    ubr = v.ubr; utarget = v.utarget; opcode = v.opcode; busy = v.busy; zero = v.zero;
    #1;
    chk({nm, ".ustall"}, 32'(ustall), 32'(v.exp_stall));
    @(posedge clock);
    #1;
    chk({nm, ".upc"}, 32'(upc), 32'(v.exp_upc));
    chk({nm, ".illegal"}, 32'(illegal), 32'(v.exp_ill));
    chk({nm, ".halted"}, 32'(halted), 32'(v.exp_halt));
    @(negedge clock);
  endtask

  task automatic chk_reset_state(input string nm);
    chk({nm, ".upc"}, 32'(upc), 32'h0);
    chk({nm, ".illegal"}, 32'(illegal), 32'h0);
    chk({nm, ".halted"}, 32'(halted), 32'h0);
    chk({nm, ".ucycles"}, ucycles, 32'h0);
    chk({nm, ".retired"}, retired, 32'h0);
  endtask

  initial begin
    int p1;
    checks = 0; errors = 0; ntbl = 0;
    reset = 1'b0; ubr = N; utarget = 8'h00; opcode = 7'h00; busy = 1'b0; zero = 1'b0;

    // Main sequence from reset: count, dispatch, spin, branches, wrap, halt.
    add(mk(N,  8'h00, 7'h00,       0, 0, 8'h01, 0, 0, 0));
    add(mk(N,  8'h00, 7'h00,       0, 0, 8'h02, 0, 0, 0));
    add(mk(N,  8'h00, 7'h00,       0, 0, 8'h03, 0, 0, 0));
    add(mk(D,  8'h00, 7'b0110011,  1, 1, 8'h10, 0, 0, 0));
    add(mk(D,  8'h00, 7'b0010011,  0, 0, 8'h20, 0, 0, 0));
    add(mk(D,  8'h00, 7'b0000011,  0, 0, 8'h30, 0, 0, 0));
    add(mk(D,  8'h00, 7'b1100011,  0, 0, 8'h50, 0, 0, 0));
    add(mk(D,  8'h00, 7'b1101111,  0, 0, 8'h60, 0, 0, 0));
    add(mk(D,  8'h00, 7'b1100111,  0, 0, 8'h70, 0, 0, 0));
    add(mk(D,  8'h00, 7'b0110111,  0, 0, 8'h80, 0, 0, 0));
    add(mk(D,  8'h00, 7'b0010111,  0, 0, 8'h90, 0, 0, 0));
    add(mk(D,  8'h00, 7'b0100011,  0, 0, 8'h40, 0, 0, 0));
    add(mk(D,  8'h00, 7'b1111111,  0, 0, 8'hF0, 0, 1, 0));
    add(mk(F,  8'h00, 7'h00,       1, 0, 8'h00, 0, 1, 0));
    add(mk(S,  8'h00, 7'h00,       1, 0, 8'h00, 1, 1, 0));
    add(mk(S,  8'h00, 7'h00,       1, 0, 8'h00, 1, 1, 0));
    add(mk(S,  8'h00, 7'h00,       1, 0, 8'h00, 1, 1, 0));
    add(mk(S,  8'h00, 7'h00,       0, 0, 8'h01, 0, 1, 0));
    add(mk(J,  8'h05, 7'h00,       0, 0, 8'h05, 0, 1, 0));
    add(mk(EZ, 8'h22, 7'h00,       0, 1, 8'h22, 0, 1, 0));
    add(mk(J,  8'h05, 7'h00,       0, 0, 8'h05, 0, 1, 0));
    add(mk(EZ, 8'h22, 7'h00,       0, 0, 8'h06, 0, 1, 0));
    add(mk(NZ, 8'h30, 7'h00,       0, 0, 8'h30, 0, 1, 0));
    add(mk(NZ, 8'h77, 7'h00,       0, 1, 8'h31, 0, 1, 0));
    add(mk(N,  8'h99, 7'h00,       1, 1, 8'h32, 0, 1, 0));
    add(mk(J,  8'hFF, 7'h00,       0, 0, 8'hFF, 0, 1, 0));
    add(mk(N,  8'h00, 7'h00,       0, 0, 8'h00, 0, 1, 0));
    add(mk(J,  8'h07, 7'h00,       0, 0, 8'h07, 0, 1, 0));
    add(mk(H,  8'h55, 7'b1111111,  1, 1, 8'h07, 0, 1, 1));
    add(mk(J,  8'h55, 7'h00,       0, 0, 8'h07, 0, 1, 1));
    add(mk(S,  8'h00, 7'h00,       1, 0, 8'h07, 0, 1, 1));
    add(mk(F,  8'h00, 7'h00,       0, 0, 8'h07, 0, 1, 1));
    p1 = ntbl;
    // Counter sequence: 10 edges with two F branches, then halt.
    add(mk(N,  8'h00, 7'h00,       0, 0, 8'h01, 0, 0, 0));
    add(mk(F,  8'h00, 7'h00,       0, 0, 8'h00, 0, 0, 0));
    add(mk(N,  8'h00, 7'h00,       0, 0, 8'h01, 0, 0, 0));
    add(mk(N,  8'h00, 7'h00,       0, 0, 8'h02, 0, 0, 0));
    add(mk(F,  8'h00, 7'h00,       0, 0, 8'h00, 0, 0, 0));
    for (int i = 0; i < 5; i++)
      add(mk(N, 8'h00, 7'h00, 0, 0, 8'(i + 1), 0, 0, 0));

    // Reset held for two cycles.
    repeat (2) @(posedge clock);
    #1;
    chk_reset_state("reset_hold");
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < p1; i++)
      step(tbl[i], $sformatf("vec%0d", i));

    // Asynchronous reset while halted, observed before any clock edge.
    #2 reset = 1'b0;
    #1;
    chk_reset_state("async_reset");
    @(negedge clock);
    reset = 1'b1;
    step(mk(N, 8'h00, 7'h00, 0, 0, 8'h01, 0, 0, 0), "post_reset_n");

    // Reset in the middle of a spin restarts from upc 0.
    step(mk(J, 8'h40, 7'h00, 0, 0, 8'h40, 0, 0, 0), "spin_j");
    step(mk(S, 8'h00, 7'h00, 1, 0, 8'h40, 1, 0, 0), "spin_s");
    #2 reset = 1'b0;
    #1;
    chk("spin_reset.upc", 32'(upc), 32'h0);
    @(negedge clock);
    reset = 1'b1;
    step(mk(N, 8'h00, 7'h00, 1, 0, 8'h01, 0, 0, 0), "spin_release_n");

    // Fresh reset for the counter check.
    reset = 1'b0;
    #1;
    chk_reset_state("cnt_reset");
    @(negedge clock);
    reset = 1'b1;
    for (int i = p1; i < ntbl; i++)
      step(tbl[i], $sformatf("cnt%0d", i - p1));
`ifdef SEQ_PERF_CNT_EN
    exp_cyc = 32'd10; exp_ret = 32'd2;
`else
    exp_cyc = 32'd0;  exp_ret = 32'd0;
`endif
    chk("cnt.ucycles", ucycles, exp_cyc);
    chk("cnt.retired", retired, exp_ret);
    step(mk(H, 8'h00, 7'h00, 0, 0, 8'h05, 0, 0, 1), "cnt_halt");
`ifdef SEQ_PERF_CNT_EN
    exp_cyc = 32'd11;
`endif
    chk("cnt_halt.ucycles", ucycles, exp_cyc);
    step(mk(F, 8'h00, 7'h00, 0, 0, 8'h05, 0, 0, 1), "cnt_halted_f");
    chk("cnt_halted_f.ucycles", ucycles, exp_cyc);
    chk("cnt_halted_f.retired", retired, exp_ret);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
